// File: rtl/alu_seq.sv
// alu_seq: registered ALU. Operands and results each use a valid/ready handshake. Every op except MUL has 1-cycle latency; MUL is a WIDTH-cycle shift-add.
// Results hold while out_valid && !out_ready. in_ready is low during MUL and while an unconsumed result is stalled.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             uns,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cmp,
  output logic             ov,
  output logic             busy
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic                 muns_q, muns_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cmp_q, cmp_d;
  logic                 ov_q, ov_d;

  logic                 accept;
  logic [WIDTH:0]       sum_ext, dif_ext;
  logic                 lt_s, lt_u;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ov;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   partial, acc_sum, prod;
  logic                 mul_ov;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cmp       = cmp_q;
  assign ov        = ov_q;
  assign busy      = (state_q == MUL);

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_ov  = uns ? sum_ext[WIDTH]
                      : (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (uns ? lt_u : lt_s)};
      OP_NOR: alu_res = ~(a | b);
      OP_XOR: alu_res = a ^ b;
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_ov  = uns ? dif_ext[WIDTH]
                      : (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      default: alu_res = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; the most negative value still fits as an unsigned magnitude.
  assign a_mag = (!uns && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!uns && b[WIDTH-1]) ? -b : b;

  assign partial = mplier_q[0] ? mcand_q : '0;
  assign acc_sum = acc_q + partial;
  assign prod    = neg_q ? -acc_sum : acc_sum;
  assign mul_ov  = muns_q ? (|prod[2*WIDTH-1:WIDTH])
                          : !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    muns_d      = muns_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cmp_d       = cmp_q;
    ov_d        = ov_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = MUL;
            cnt_d    = CNT_W'(WIDTH - 1);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
            muns_d   = uns;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            cmp_d       = (alu_res == '0);
            ov_d        = alu_ov;
          end
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = prod[WIDTH-1:0];
          cmp_d       = (prod[WIDTH-1:0] == '0);
          ov_d        = mul_ov;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      muns_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      muns_q      <= muns_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cmp_q       <= cmp_d;
      ov_q        <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): scoreboard of expected results, one task per scenario.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         uns;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cmp, ov, busy;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cmp;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .uns(uns), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cmp(cmp), .ov(ov), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference using 64-bit arithmetic.
  function automatic exp_t model(input logic [2:0] f_op, input logic [W-1:0] fa,
                                 input logic [W-1:0] fb, input logic f_uns);
    exp_t        e;
    logic [63:0] wide;
    longint      sa, sb, sp;
    sa    = longint'($signed(fa));
    sb    = longint'($signed(fb));
    e     = '0;
    case (f_op)
      3'b000: e.res = fa & fb;
      3'b001: e.res = fa | fb;
      3'b010: begin
        wide  = {32'b0, fa} + {32'b0, fb};
        sp    = sa + sb;
        e.res = wide[W-1:0];
        e.ov  = f_uns ? wide[W] : (sp > SMAX || sp < SMIN);
      end
      3'b011: e.res[0] = f_uns ? (fa < fb) : (sa < sb);
      3'b100: e.res = ~(fa | fb);
      3'b101: e.res = fa ^ fb;
      3'b110: begin
        wide  = {32'b0, fa} - {32'b0, fb};
        sp    = sa - sb;
        e.res = wide[W-1:0];
        e.ov  = f_uns ? (fa < fb) : (sp > SMAX || sp < SMIN);
      end
      default: begin
        if (f_uns) begin
          wide = {32'b0, fa} * {32'b0, fb};
          e.ov = |wide[63:32];
        end else begin
          sp   = sa * sb;
          wide = sp;
          e.ov = (sp > SMAX || sp < SMIN);
        end
        e.res = wide[W-1:0];
      end
    endcase
    e.cmp = (e.res == '0);
    return e;
  endfunction

  // Presents one operand set and returns one cycle after the accepting edge (#1 past it).
  task automatic drive_op(input logic [2:0] f_op, input logic [W-1:0] fa,
                          input logic [W-1:0] fb, input logic f_uns);
    bit acc;
    op = f_op; a = fa; b = fb; uns = f_uns; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      $display("FAIL drive_op: in_ready never rose, got 0 want 1");
      $fatal(1, "operand never accepted");
    end
  endtask

  // Waits (bounded) for out_valid; cycles = edges after the accept edge.
  task automatic get_out(input int budget, output bit got, output exp_t obs, output int cycles,
                         output int busy_n, output int rdy_busy_n);
    got = 1'b0; obs = '0; cycles = 0; busy_n = 0; rdy_busy_n = 0;
    while (cycles <= budget) begin
      if (out_valid) begin
        got = 1'b1;
        obs = {result, cmp, ov};
        break;
      end
      if (busy) busy_n++;
      if (busy && in_ready) rdy_busy_n++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    bit got; exp_t obs, e; int cyc, bn, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; uns = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_mis++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if ({cmp, ov, busy} !== 3'b000) begin n_mis++; $display("FAIL reset_flags: got cmp/ov/busy=%b want 000", {cmp, ov, busy}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    exp_q.push_back('{res: 32'hFFFF_FFFF, cmp: 1'b0, ov: 1'b0});
    drive_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    get_out(5, got, obs, cyc, bn, rb);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_cmp++; if (!got || cyc != 0) begin n_mis++; $display("FAIL and_latency: got valid=%b after %0d extra cycles want valid after 0", got, cyc); end
    n_cmp++; if (obs !== e) begin n_mis++; $display("FAIL and_value: got %h/%b/%b want %h/%b/%b", obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
  endtask

  task automatic test_arith;
    logic [2:0] t_op [10] = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b110, 3'b011, 3'b011, 3'b110, 3'b001, 3'b101};
    logic [W-1:0] t_a [10] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 32'd1, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_00F0, 32'h1234_5678};
    logic [W-1:0] t_b [10] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'd1, 32'd1,
                               32'd1, 32'd1, 32'd1, 32'h0000_000F, 32'h1234_5678};
    logic t_u [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_t t_e [10] = '{'{32'hFFFF_FFFE, 1'b0, 1'b1}, '{32'h0000_0002, 1'b0, 1'b1},
                       '{32'h0000_0000, 1'b1, 1'b0}, '{32'h0000_0000, 1'b1, 1'b0},
                       '{32'hFFFF_FFFF, 1'b0, 1'b1}, '{32'h0000_0001, 1'b0, 1'b0},
                       '{32'h0000_0000, 1'b1, 1'b0}, '{32'h7FFF_FFFF, 1'b0, 1'b1},
                       '{32'h0000_00FF, 1'b0, 1'b0}, '{32'h0000_0000, 1'b1, 1'b0}};
    bit got; exp_t obs, e; int cyc, bn, rb;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(t_e[i]);
      drive_op(t_op[i], t_a[i], t_b[i], t_u[i]);
      get_out(5, got, obs, cyc, bn, rb);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_cmp++; if (!got || cyc != 0) begin n_mis++; $display("FAIL arith_latency[%0d]: got valid=%b after %0d extra cycles want 0", i, got, cyc); end
      n_cmp++; if (obs !== e) begin n_mis++; $display("FAIL arith_value[%0d]: got %h/%b/%b want %h/%b/%b", i, obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] m_a [9] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic [W-1:0] m_b [9] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic m_u [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t m_e [6] = '{'{32'hFFFF_FFEB, 1'b0, 1'b0}, '{32'h0000_0000, 1'b1, 1'b1},
                      '{32'h0000_0000, 1'b1, 1'b1}, '{32'h8000_0000, 1'b0, 1'b0},
                      '{32'h0000_0001, 1'b0, 1'b1}, '{32'h0000_0001, 1'b0, 1'b0}};
    bit got; exp_t obs, e; int cyc, bn, rb;
    for (int i = 6; i < 9; i++) begin
      m_a[i] = $urandom;
      m_b[i] = (i == 8) ? 32'($urandom_range(0, 4095)) : $urandom;
    end
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back((i < 6) ? m_e[i] : model(3'b111, m_a[i], m_b[i], m_u[i]));
      drive_op(3'b111, m_a[i], m_b[i], m_u[i]);
      op = 3'b010; a = $urandom; b = $urandom; in_valid = 1'b1;
      get_out(60, got, obs, cyc, bn, rb);
      in_valid = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_cmp++; if (!got || cyc != W) begin n_mis++; $display("FAIL mul_latency[%0d]: got valid=%b at %0d cycles want %0d", i, got, cyc, W); end
      n_cmp++; if (bn != W) begin n_mis++; $display("FAIL mul_busy_cycles[%0d]: got %0d want %0d", i, bn, W); end
      n_cmp++; if (rb != 0) begin n_mis++; $display("FAIL mul_in_ready_while_busy[%0d]: got %0d cycles want 0", i, rb); end
      n_cmp++; if (obs !== e) begin n_mis++; $display("FAIL mul_value[%0d]: got %h/%b/%b want %h/%b/%b", i, obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL mul_busy_done[%0d]: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t obs, e;
    for (int i = 0; i < 24; i++) begin
      op  = 3'($urandom_range(0, 6));
      a   = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      b   = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
      uns = 1'($urandom_range(0, 1));
      exp_q.push_back(model(op, a, b, uns));
      in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      obs = {result, cmp, ov};
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_mis++; $display("FAIL b2b_value[%0d]: got v=%b %h/%b/%b want v=1 %h/%b/%b", i, out_valid, obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_drain: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    exp_t obs, e;
    out_ready = 1'b0;
    exp_q.push_back('{res: 32'h0000_0001, cmp: 1'b0, ov: 1'b0});
    drive_op(3'b101, 32'd1, 32'd0, 1'b0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    op = 3'b100; a = '0; b = '0; uns = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      obs = {result, cmp, ov};
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_handshake[%0d]: got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      n_cmp++; if (obs !== e) begin n_mis++; $display("FAIL bp_hold[%0d]: got %h/%b/%b want %h/%b/%b", i, obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp_q.push_back('{res: 32'hFFFF_FFFF, cmp: 1'b0, ov: 1'b0});
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs = {result, cmp, ov};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_mis++; $display("FAIL bp_same_edge: got v=%b %h/%b/%b want v=1 %h/%b/%b", out_valid, obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_retire: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul;
    bit got; exp_t obs, e; int cyc, bn, rb, seen;
    drive_op(3'b111, 32'd12345, 32'd678, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL rst_mid_immediate: got out_valid=%b busy=%b want 0/0", out_valid, busy); end
    n_cmp++; if (result !== '0) begin n_mis++; $display("FAIL rst_mid_result: got %h want 0", result); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen != 0) begin n_mis++; $display("FAIL rst_mid_no_partial: got %0d active cycles want 0", seen); end
    exp_q.push_back('{res: 32'd2, cmp: 1'b0, ov: 1'b0});
    drive_op(3'b010, 32'd1, 32'd1, 1'b0);
    get_out(5, got, obs, cyc, bn, rb);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_cmp++; if (!got || cyc != 0) begin n_mis++; $display("FAIL rst_mid_add_latency: got valid=%b after %0d extra cycles want 0", got, cyc); end
    n_cmp++; if (obs !== e) begin n_mis++; $display("FAIL rst_mid_add_value: got %h/%b/%b want %h/%b/%b", obs.res, obs.cmp, obs.ov, e.res, e.cmp, e.ov); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational 32-bit ALU. Same op set and flags (cmp, ov, signed/unsigned select), plus a set-less-than op and an iterative multiply. Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake, so the block can sit in a pipelined execute stage that stalls on backpressure.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 4..64)
CNT_W, $clog2(WIDTH), width of the multiply iteration counter

Ports:
clk        in   1      rising-edge clock
rst        in   1      asynchronous, active-high reset
in_valid   in   1      operand set valid
in_ready   out  1      block can accept an operand set
a          in   WIDTH  operand A
b          in   WIDTH  operand B
op         in   3      operation select
uns        in   1      1 = unsigned, 0 = two's-complement signed
out_valid  out  1      result valid
out_ready  in   1      consumer accepts result
result     out  WIDTH  operation result
cmp        out  1      zero flag: result == 0
ov         out  1      overflow / carry flag
busy       out  1      multiply in progress

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, result=0, cmp=0, ov=0, busy=0, state=IDLE, mul counter=0, accumulator=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept condition: in_valid && in_ready at a rising edge. a, b, op and uns are captured at that edge.
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 011 SLT, 100 NOR, 101 XOR, 110 SUB, 111 MUL.
  - SLT returns result = {0..0, a<b}; the comparison is signed when uns=0, unsigned when uns=1.
- Single-cycle ops (all except MUL):
  - result, cmp and ov are registered at the accept edge.
  - out_valid=1 after that edge, i.e. latency 1.
  - Back-to-back accepts are allowed while out_ready=1, giving 1 result per cycle.
- Overflow rules:
  - ADD, uns=1: ov = carry out of bit WIDTH-1.
  - ADD, uns=0: ov = signed overflow (operand signs equal and result sign differs).
  - SUB, uns=1: ov = borrow (a<b).
  - SUB, uns=0: ov = signed overflow (operand signs differ and result sign differs from a).
  - All logic ops and SLT: ov=0.
- MUL FSM (states IDLE, MUL):
  - Accept in IDLE with op=111: go to MUL and set busy=1.
  - Captured operands become magnitudes when uns=0. The sign is stored as sign(a) XOR sign(b).
  - The 2*WIDTH-bit accumulator clears to 0. The counter loads WIDTH-1.
  - Each cycle in MUL: shift-add one multiplier bit (LSB first) and decrement the counter.
  - On the cycle the counter reaches 0:
    - apply the sign (two's-complement negate the 2*WIDTH product if the sign is set);
    - result = low WIDTH bits, out_valid=1, busy=0, return to IDLE.
  - Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- MUL overflow:
  - uns=1: ov = |high half.
  - uns=0: ov = 1 unless the high half plus result MSB are all-0 or all-1.
- cmp = (result == 0) for every op. It is registered together with result.
- Output hold: while out_valid && !out_ready, result, cmp and ov stay stable and no new operand is accepted.
- out_valid clears on the handshake edge unless a new single-cycle op is accepted on the same edge; in that case out_valid stays 1 with the new result.
- Simultaneous events: out_ready and in_valid in the same cycle while out_valid=1 → the old result retires and the new op is accepted in the same edge.
- in_valid during MUL is ignored (in_ready=0). Operands changing mid-multiply have no effect.
- Reset mid-operation: an asynchronous rst aborts the multiply, returns to IDLE and drops out_valid immediately. No partial result is ever presented.
- Unused encodings: none; all 8 op codes are defined.

Test Plan:
1. Reset then release, WIDTH=32: out_valid=0, result=0, in_ready=1. AND a=0xFFFFFFFF b=0xFFFFFFFF → next cycle result=0xFFFFFFFF, cmp=0, ov=0.
2. ADD uns=1 a=0xFFFFFFFF b=0xFFFFFFFF → result=0xFFFFFFFE, ov=1. ADD uns=0 a=-2147483647 b=-2147483647 → result=0x00000002, ov=1. ADD uns=0 a=-2147483647 b=2147483647 → result=0, cmp=1, ov=0.
3. SUB uns=1 a=1 b=1 → result=0, cmp=1, ov=0. SUB uns=1 a=0 b=1 → result=0xFFFFFFFF, ov=1. SLT uns=0 a=-1 b=1 → result=1. SLT uns=1 a=0xFFFFFFFF b=1 → result=0, cmp=1.
4. MUL uns=0 a=-3 b=7 → busy for 32 cycles, out_valid exactly 32 cycles after accept, result=0xFFFFFFEB, ov=0. MUL uns=1 a=0x10000 b=0x10000 → result=0, ov=1, cmp=1.
5. Backpressure: hold out_ready=0 after an XOR a=1 b=0 result (result=1). in_ready=0 and result is stable for 5 cycles. Raise out_ready with in_valid=1 (NOR a=0 b=0) → same-edge retire and accept; next result=0xFFFFFFFF.
6. Assert rst 10 cycles into a MUL → out_valid=0 and busy=0 immediately. After release, the first ADD 1+1 → result=2 with latency 1.
